// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: follows destination register and Tnew through E/M/W,
// resolves forwarding source and wait status for the D operands, and counts stall cycles.
module hazard_tracker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [4:0]  D_A3,
  input  logic [1:0]  D_Tnew,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic        stat_clr,
  output logic [4:0]  E_A3,
  output logic [4:0]  M_A3,
  output logic [4:0]  W_A3,
  output logic [1:0]  E_Tnew,
  output logic [1:0]  M_Tnew,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic        rs_wait,
  output logic        rt_wait,
  output logic        hazard_pending,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] SEL_GRF = 2'd0;
  localparam logic [1:0] SEL_E   = 2'd1;
  localparam logic [1:0] SEL_M   = 2'd2;
  localparam logic [1:0] SEL_W   = 2'd3;

  logic [4:0]  e_a3_r;
  logic [4:0]  m_a3_r;
  logic [4:0]  w_a3_r;
  logic [1:0]  e_tnew_r;
  logic [1:0]  m_tnew_r;
  logic [15:0] stall_cnt_r;
  logic [2:0]  rs_res_s;
  logic [2:0]  rt_res_s;

  // Result is {wait, sel}; only the youngest stage naming the operand decides.
  function automatic logic [2:0] resolve(
    input logic [4:0] src,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew,
    input logic [4:0] w_a3
  );
    logic [2:0] res;
    res = {1'b0, SEL_GRF};
    if (src == 5'd0) begin
      res = {1'b0, SEL_GRF};
    end else if (src == e_a3) begin
      res = (e_tnew == 2'd0) ? {1'b0, SEL_E} : {1'b1, SEL_GRF};
    end else if (src == m_a3) begin
      res = (m_tnew == 2'd0) ? {1'b0, SEL_M} : {1'b1, SEL_GRF};
    end else if (src == w_a3) begin
      res = {1'b0, SEL_W};
    end else begin
      res = {1'b0, SEL_GRF};
    end
    return res;
  endfunction

  // Stage registers; a stall drops a bubble into E while M and W keep draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_a3_r   <= 5'd0;
      e_tnew_r <= 2'd0;
      m_a3_r   <= 5'd0;
      m_tnew_r <= 2'd0;
      w_a3_r   <= 5'd0;
    end else begin
      if (stall) begin
        e_a3_r   <= 5'd0;
        e_tnew_r <= 2'd0;
      end else begin
        e_a3_r   <= D_A3;
        e_tnew_r <= (D_A3 == 5'd0) ? 2'd0 : D_Tnew;
      end
      m_a3_r   <= e_a3_r;
      m_tnew_r <= (e_tnew_r == 2'd0) ? 2'd0 : (e_tnew_r - 2'd1);
      w_a3_r   <= m_a3_r;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 16'd0;
    end else if (stat_clr) begin
      stall_cnt_r <= 16'd0;
    end else if (stall && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Operand resolution is purely combinational so D sees it in the same cycle.
  always_comb begin
    rs_res_s = {1'b0, SEL_GRF};
    rt_res_s = {1'b0, SEL_GRF};
    rs_res_s = resolve(D_rs, e_a3_r, e_tnew_r, m_a3_r, m_tnew_r, w_a3_r);
    rt_res_s = resolve(D_rt, e_a3_r, e_tnew_r, m_a3_r, m_tnew_r, w_a3_r);
  end

  assign E_A3           = e_a3_r;
  assign M_A3           = m_a3_r;
  assign W_A3           = w_a3_r;
  assign E_Tnew         = e_tnew_r;
  assign M_Tnew         = m_tnew_r;
  assign stall_cnt      = stall_cnt_r;
  assign fwd_rs_sel     = rs_res_s[1:0];
  assign fwd_rt_sel     = rt_res_s[1:0];
  assign rs_wait        = rs_res_s[2];
  assign rt_wait        = rt_res_s[2];
  assign hazard_pending = rs_res_s[2] | rt_res_s[2];

endmodule
